// File: rtl/seg_pkg.sv
// Shared types and sizes for the 8-digit hex display scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIG_W      = 4;
  localparam int IDX_W      = 3;

  typedef logic [NUM_DIGITS-1:0][DIG_W-1:0] dig_vec_t;

  // Bit i is set when any digit at position i or above is nonzero, i.e. the
  // digit is not part of the run of leading zeros.
  function automatic logic [NUM_DIGITS-1:0] lead_mask(input dig_vec_t dv);
    logic seen;
    seen      = 1'b0;
    lead_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen         = seen | (dv[i] != '0);
      lead_mask[i] = seen;
    end
  endfunction

endpackage

// File: rtl/seg_next_idx.sv
// Next-enabled-digit search: first enabled index after cur, modulo NUM_DIGITS.
// Index 0 is expected to be always enabled so the search lands somewhere.
module seg_next_idx
  import seg_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] en,
  input  logic [IDX_W-1:0]      cur,
  output logic [IDX_W-1:0]      nxt,
  output logic                  wrap
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Priority search cur+1, cur+2, ... ; the last step (cur+8) returns to cur
  // itself, which covers the single-enabled-digit case.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_DIGITS; i++) begin
      idx = cur + IDX_W'(i);
      if (!found && en[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    // Landing at or below the starting point means the search passed index 0.
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit hex display: digit storage,
// dwell prescaler, leading-zero mask and registered index/value/frame outputs.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV    = 100000,
  parameter bit LZS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ld,
  input  logic [31:0] ld_val,
  input  logic        wr,
  input  logic [2:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic        lzs,
  output logic [2:0]  an,
  output logic [3:0]  d,
  output logic        frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  dig_vec_t              dig;
  logic [CW-1:0]         cnt;
  logic                  dwell_end;
  logic [NUM_DIGITS-1:0] en;
  logic [IDX_W-1:0]      nxt;
  logic                  wrap;

  // Digit storage: a full-word load takes priority over a single-digit write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dig <= '0;
    end else if (ld) begin
      dig <= ld_val;
    end else if (wr) begin
      dig[wr_addr] <= wr_data;
    end
  end

  // Enable mask from the stored digits; digit 0 is always shown.
  always_comb begin
    en    = (LZS_EN && lzs) ? lead_mask(dig) : '1;
    en[0] = 1'b1;
  end

  assign dwell_end = (cnt == CW'(DIV - 1));

  // Dwell prescaler, free-running 0..DIV-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (dwell_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  seg_next_idx u_next (
    .en   (en),
    .cur  (an),
    .nxt  (nxt),
    .wrap (wrap)
  );

  // Output registers: advance at dwell end, otherwise keep refreshing d from
  // the stored digit so writes to the shown digit appear one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an    <= '0;
      d     <= '0;
      frame <= 1'b0;
    end else if (dwell_end) begin
      an    <= nxt;
      d     <= dig[nxt];
      frame <= wrap;
    end else begin
      d     <= dig[an];
      frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=4.
module tb_seg_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld;
  logic [31:0] ld_val;
  logic        wr;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        lzs;
  logic [2:0]  an;
  logic [3:0]  d;
  logic        frame;

  int tests = 0;
  int fails = 0;

  seg_scan_ctrl #(.DIV(DIV), .LZS_EN(1'b1)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .ld      (ld),
    .ld_val  (ld_val),
    .wr      (wr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .lzs     (lzs),
    .an      (an),
    .d       (d),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      val;
    logic             lzs;
    int               n;     // enabled digits per frame
    logic [7:0][2:0]  ean;   // expected an per dwell
    logic [7:0][3:0]  ed;    // expected d per dwell
  } row_t;

  row_t rows[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_frame(input string nm);
    int i;
    i = 0;
    while (frame !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_frame_seen"}, {31'd0, frame}, 32'd1);
  endtask

  // Load a word at a negedge, let the load edge pass, then align to a frame.
  task automatic do_load(input logic [31:0] v, input logic z, input string nm);
    ld = 1'b1; ld_val = v; lzs = z;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    wait_frame(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] ident;
    int          k;
    ident = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    rows[0] = '{val: 32'h87654321, lzs: 1'b0, n: 8, ean: ident, ed: 32'h87654321};
    rows[1] = '{val: 32'h00000A05, lzs: 1'b1, n: 3, ean: ident, ed: 32'h00000A05};
    rows[2] = '{val: 32'h00000A05, lzs: 1'b0, n: 8, ean: ident, ed: 32'h00000A05};
    rows[3] = '{val: 32'h00000000, lzs: 1'b1, n: 1, ean: ident, ed: 32'h00000000};
    rows[4] = '{val: 32'h00F00000, lzs: 1'b1, n: 6, ean: ident, ed: 32'h00F00000};
    rows[5] = '{val: 32'h80000000, lzs: 1'b1, n: 8, ean: ident, ed: 32'h80000000};

    rstn = 1'b0; ld = 1'b0; ld_val = '0; wr = 1'b0; wr_addr = '0; wr_data = '0; lzs = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 0);
    chk("rst_d", d, 0);
    chk("rst_frame", frame, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Table: for each row, one full frame checked cycle by cycle.
    for (int r = 0; r < 6; r++) begin
      do_load(rows[r].val, rows[r].lzs, $sformatf("row%0d", r));
      for (int j = 0; j < rows[r].n; j++) begin
        for (int c = 0; c < DIV; c++) begin
          chk($sformatf("row%0d_an_k%0d", r, j), an, rows[r].ean[j]);
          chk($sformatf("row%0d_d_k%0d", r, j), d, rows[r].ed[j]);
          chk($sformatf("row%0d_frame_k%0d_c%0d", r, j, c), frame, (j == 0 && c == 0) ? 1 : 0);
          @(negedge clk);
        end
      end
      chk($sformatf("row%0d_wrap_frame", r), frame, 1);
      chk($sformatf("row%0d_wrap_an", r), an, 0);
    end

    // Write to the digit currently shown: one-cycle latency, dwell untouched.
    do_load(32'h87654321, 1'b0, "wrcur");
    repeat (3 * DIV + 1) @(negedge clk);
    chk("wrcur_an", an, 3);
    chk("wrcur_d_before", d, 4);
    wr = 1'b1; wr_addr = 3'd3; wr_data = 4'hE;
    @(negedge clk);
    wr = 1'b0;
    chk("wrcur_d_lat", d, 4);
    chk("wrcur_an_hold", an, 3);
    @(negedge clk);
    chk("wrcur_d_new", d, 4'hE);
    chk("wrcur_an_hold2", an, 3);
    @(negedge clk);
    chk("wrcur_adv_an", an, 4);
    chk("wrcur_adv_d", d, 5);

    // Load and write together: the load wins.
    ld = 1'b1; ld_val = 32'h11111111; wr = 1'b1; wr_addr = 3'd2; wr_data = 4'hC;
    @(negedge clk);
    ld = 1'b0; wr = 1'b0;
    k = 0;
    while (an !== 3'd2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ldwr_reach_an2", an, 2);
    chk("ldwr_d", d, 1);

    // Reset in the middle of digit 5's dwell.
    do_load(32'h87654321, 1'b0, "rstmid");
    repeat (5 * DIV + 1) @(negedge clk);
    chk("rstmid_an5", an, 5);
    chk("rstmid_d6", d, 6);
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_an", an, 0);
    chk("rstmid_d", d, 0);
    chk("rstmid_frame", frame, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 1; c < DIV; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_hold_c%0d", c), an, 0);
    end
    @(negedge clk);
    chk("rstmid_adv_an", an, 1);
    chk("rstmid_adv_d", d, 0);
    chk("rstmid_adv_frame", frame, 0);

    // Shown digit becomes a leading zero mid-dwell: finish dwell, then wrap.
    do_load(32'h00F00000, 1'b1, "lzmid");
    repeat (5 * DIV) @(negedge clk);
    chk("lzmid_an5", an, 5);
    chk("lzmid_dF", d, 4'hF);
    wr = 1'b1; wr_addr = 3'd5; wr_data = 4'h0;
    for (int c = 1; c < DIV; c++) begin
      @(negedge clk);
      wr = 1'b0;
      chk($sformatf("lzmid_hold_c%0d", c), an, 5);
      chk($sformatf("lzmid_nofr_c%0d", c), frame, 0);
    end
    @(negedge clk);
    chk("lzmid_wrap_an", an, 0);
    chk("lzmid_wrap_frame", frame, 1);
    chk("lzmid_wrap_d", d, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
